// File: rtl/dest_reg_pipeline.sv
// dest_reg_pipeline: tracks destination registers of in-flight instructions
// from IF/ID decode through ID/EXE, EXE/MEM and MEM/WB. It feeds the
// write-enable / destination buses compared by the interlock, inserts bubbles
// on stall or flush, and keeps saturating stall/bubble counters.
module dest_reg_pipeline #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            if_id_opcode,
    input  logic [REG_ADDR_W-1:0] if_id_write_reg,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  id_exe_regWrite,
    output logic                  exe_mem_regWrite,
    output logic                  mem_wb_regWrite,
    output logic [REG_ADDR_W-1:0] id_exe_write_reg,
    output logic [REG_ADDR_W-1:0] exe_mem_write_reg,
    output logic [REG_ADDR_W-1:0] mem_wb_write_reg,
    output logic                  id_exe_memRead,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      bubble_count
);

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                  dec_reg_write;
    logic                  dec_mem_read;
    logic [REG_ADDR_W-1:0] dec_write_reg;
    logic                  insert_bubble;

    logic                  id_exe_rw_q,  id_exe_rw_d;
    logic [REG_ADDR_W-1:0] id_exe_wr_q,  id_exe_wr_d;
    logic                  id_exe_mr_q,  id_exe_mr_d;
    logic                  exe_mem_rw_q, exe_mem_rw_d;
    logic [REG_ADDR_W-1:0] exe_mem_wr_q, exe_mem_wr_d;
    logic                  mem_wb_rw_q,  mem_wb_rw_d;
    logic [REG_ADDR_W-1:0] mem_wb_wr_q,  mem_wb_wr_d;
    logic [CNT_W-1:0]      stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

    // Decode regWrite/memRead for the IF/ID instruction; rd==x0 never writes.
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_write_reg = '0;
        unique case (if_id_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                dec_reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            default: begin
                dec_reg_write = 1'b0;
            end
        endcase
        if (if_id_write_reg == '0) begin
            dec_reg_write = 1'b0;
            dec_mem_read  = 1'b0;
        end
        if (dec_reg_write) begin
            dec_write_reg = if_id_write_reg;
        end
    end

    // Next-state for the stage registers and saturating counters.
    always_comb begin
        insert_bubble = stall | flush;

        mem_wb_rw_d  = exe_mem_rw_q;
        mem_wb_wr_d  = exe_mem_wr_q;
        exe_mem_rw_d = id_exe_rw_q;
        exe_mem_wr_d = id_exe_wr_q;

        id_exe_rw_d = dec_reg_write;
        id_exe_wr_d = dec_write_reg;
        id_exe_mr_d = dec_mem_read;
        if (insert_bubble) begin
            id_exe_rw_d = 1'b0;
            id_exe_wr_d = '0;
            id_exe_mr_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        bubble_cnt_d = bubble_cnt_q;
        if (insert_bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_exe_rw_q  <= 1'b0;
            id_exe_wr_q  <= '0;
            id_exe_mr_q  <= 1'b0;
            exe_mem_rw_q <= 1'b0;
            exe_mem_wr_q <= '0;
            mem_wb_rw_q  <= 1'b0;
            mem_wb_wr_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            id_exe_rw_q  <= id_exe_rw_d;
            id_exe_wr_q  <= id_exe_wr_d;
            id_exe_mr_q  <= id_exe_mr_d;
            exe_mem_rw_q <= exe_mem_rw_d;
            exe_mem_wr_q <= exe_mem_wr_d;
            mem_wb_rw_q  <= mem_wb_rw_d;
            mem_wb_wr_q  <= mem_wb_wr_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Flush overrides stall: squashed IF/ID must be refetched.
    assign pc_enable    = ~stall | flush;
    assign if_id_enable = ~stall | flush;

    assign id_exe_regWrite   = id_exe_rw_q;
    assign id_exe_write_reg  = id_exe_wr_q;
    assign id_exe_memRead    = id_exe_mr_q;
    assign exe_mem_regWrite  = exe_mem_rw_q;
    assign exe_mem_write_reg = exe_mem_wr_q;
    assign mem_wb_regWrite   = mem_wb_rw_q;
    assign mem_wb_write_reg  = mem_wb_wr_q;
    assign stall_count       = stall_cnt_q;
    assign bubble_count      = bubble_cnt_q;

endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Testbench for dest_reg_pipeline (CNT_W=4 so saturation is reachable).
module tb_dest_reg_pipeline;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          rw;
        logic [RW-1:0] wr;
        logic          mr;
    } stage_t;

    typedef struct {
        logic [6:0]    opc;
        logic [RW-1:0] rd;
        logic          stall;
        logic          flush;
        stage_t        exp;
        logic          exp_pc;
    } vec_t;

    logic          clock;
    logic          reset;
    logic [6:0]    if_id_opcode;
    logic [RW-1:0] if_id_write_reg;
    logic          stall;
    logic          flush;
    logic          id_exe_regWrite, exe_mem_regWrite, mem_wb_regWrite;
    logic [RW-1:0] id_exe_write_reg, exe_mem_write_reg, mem_wb_write_reg;
    logic          id_exe_memRead;
    logic          pc_enable, if_id_enable;
    logic [CW-1:0] stall_count, bubble_count;

    int checks = 0;
    int errors = 0;

    stage_t        hist[$];
    logic [CW-1:0] exp_sc, exp_bc;
    vec_t          vecs[16];

    dest_reg_pipeline #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .if_id_opcode     (if_id_opcode),
        .if_id_write_reg  (if_id_write_reg),
        .stall            (stall),
        .flush            (flush),
        .id_exe_regWrite  (id_exe_regWrite),
        .exe_mem_regWrite (exe_mem_regWrite),
        .mem_wb_regWrite  (mem_wb_regWrite),
        .id_exe_write_reg (id_exe_write_reg),
        .exe_mem_write_reg(exe_mem_write_reg),
        .mem_wb_write_reg (mem_wb_write_reg),
        .id_exe_memRead   (id_exe_memRead),
        .pc_enable        (pc_enable),
        .if_id_enable     (if_id_enable),
        .stall_count      (stall_count),
        .bubble_count     (bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stage_t st(input logic rw, input logic [RW-1:0] wr, input logic mr);
        stage_t s;
        s.rw = rw;
        s.wr = wr;
        s.mr = mr;
        return s;
    endfunction

    function automatic vec_t mk(input logic [6:0] o, input logic [RW-1:0] r, input logic s,
                                input logic f, input logic rw, input logic [RW-1:0] wr,
                                input logic mr, input logic pe);
        vec_t v;
        v.opc    = o;
        v.rd     = r;
        v.stall  = s;
        v.flush  = f;
        v.exp    = st(rw, wr, mr);
        v.exp_pc = pe;
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(st(1'b0, '0, 1'b0));
        exp_sc = '0;
        exp_bc = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_id_rw"}, 32'(id_exe_regWrite), 32'd0);
        chk({tag, "_id_wr"}, 32'(id_exe_write_reg), 32'd0);
        chk({tag, "_id_mr"}, 32'(id_exe_memRead), 32'd0);
        chk({tag, "_em_rw"}, 32'(exe_mem_regWrite), 32'd0);
        chk({tag, "_em_wr"}, 32'(exe_mem_write_reg), 32'd0);
        chk({tag, "_mw_rw"}, 32'(mem_wb_regWrite), 32'd0);
        chk({tag, "_mw_wr"}, 32'(mem_wb_write_reg), 32'd0);
        chk({tag, "_scnt"}, 32'(stall_count), 32'd0);
        chk({tag, "_bcnt"}, 32'(bubble_count), 32'd0);
    endtask

    // Drive one instruction, check enables, clock it, then compare all stages.
    task automatic step(input string tag, input vec_t v);
        if_id_opcode    = v.opc;
        if_id_write_reg = v.rd;
        stall           = v.stall;
        flush           = v.flush;
        #1;
        chk({tag, "_pc_en"}, 32'(pc_enable), 32'(v.exp_pc));
        chk({tag, "_ifid_en"}, 32'(if_id_enable), 32'(v.exp_pc));
        hist.push_back(v.exp);
        void'(hist.pop_front());
        if (v.stall && exp_sc != '1) exp_sc = exp_sc + CW'(1);
        if ((v.stall || v.flush) && exp_bc != '1) exp_bc = exp_bc + CW'(1);
        @(posedge clock);
        #1;
        chk({tag, "_id_rw"}, 32'(id_exe_regWrite), 32'(hist[2].rw));
        chk({tag, "_id_wr"}, 32'(id_exe_write_reg), 32'(hist[2].wr));
        chk({tag, "_id_mr"}, 32'(id_exe_memRead), 32'(hist[2].mr));
        chk({tag, "_em_rw"}, 32'(exe_mem_regWrite), 32'(hist[1].rw));
        chk({tag, "_em_wr"}, 32'(exe_mem_write_reg), 32'(hist[1].wr));
        chk({tag, "_mw_rw"}, 32'(mem_wb_regWrite), 32'(hist[0].rw));
        chk({tag, "_mw_wr"}, 32'(mem_wb_write_reg), 32'(hist[0].wr));
        chk({tag, "_scnt"}, 32'(stall_count), 32'(exp_sc));
        chk({tag, "_bcnt"}, 32'(bubble_count), 32'(exp_bc));
    endtask

    // Assert reset with random inputs, then release away from the clock edge.
    task automatic apply_reset(input string tag);
        reset           = 1'b0;
        if_id_opcode    = 7'($urandom);
        if_id_write_reg = RW'($urandom);
        stall           = 1'($urandom);
        flush           = 1'($urandom);
        #1;
        chk_zero({tag, "_in"});
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_zero({tag, "_rel"});
    endtask

    initial begin
        vecs[0]  = mk(7'b0010011, 5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1);
        vecs[1]  = mk(7'b0110111, 5'd1,  1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 1'b1);
        vecs[2]  = mk(7'b0010111, 5'd2,  1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 1'b1);
        vecs[3]  = mk(7'b1101111, 5'd31, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b1);
        vecs[4]  = mk(7'b1100111, 5'd6,  1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 1'b1);
        vecs[5]  = mk(7'b0110011, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[6]  = mk(7'b0100011, 5'd7,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[7]  = mk(7'b1100011, 5'd9,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[8]  = mk(7'b0000011, 5'd3,  1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 1'b1);
        vecs[9]  = mk(7'b0000011, 5'd4,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        vecs[10] = mk(7'b0000011, 5'd4,  1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1);
        vecs[11] = mk(7'b0110011, 5'd8,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[12] = mk(7'b0110011, 5'd8,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[13] = mk(7'b1111111, 5'd10, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[14] = mk(7'b0000011, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        vecs[15] = mk(7'b0110011, 5'd12, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b1);

        apply_reset("rst0");

        // Main vector table, followed by idle cycles that drain the pipeline.
        for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), vecs[i]);
        for (int i = 0; i < 3; i++)
            step($sformatf("drain%0d", i), mk(7'b0100011, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1));

        // Saturation: stall held 20 cycles, then counters must hold at 15.
        apply_reset("rst1");
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), mk(7'b0010011, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        chk("sat_scnt_max", 32'(stall_count), 32'd15);
        chk("sat_bcnt_max", 32'(bubble_count), 32'd15);
        step("sat_flush", mk(7'b0010011, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1));
        step("sat_run", mk(7'b0010011, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1));
        chk("sat_hold_scnt", 32'(stall_count), 32'd15);

        // Reset mid-stall clears state immediately; first unstalled edge loads IF/ID.
        apply_reset("rst2");
        step("ms_a", mk(7'b0110011, 5'd11, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1));
        step("ms_b", mk(7'b0000011, 5'd13, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        step("ms_c", mk(7'b0000011, 5'd13, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        #2;
        reset = 1'b0;
        #1;
        chk_zero("ms_async");
        model_reset();
        @(negedge clock);
        stall = 1'b0;
        reset = 1'b1;
        step("ms_post", mk(7'b0000011, 5'd13, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1, 1'b1));
        step("ms_post2", mk(7'b0010011, 5'd14, 1'b0, 1'b0, 1'b1, 5'd14, 1'b0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
